clint_bridge: RTL and testbench
===============================

Name: clint_bridge

Overview:
- Memory-mapped CLINT front end, directly downstream of the RV cluster's data port.
- Decodes the cluster's data-side write and read requests that fall in the CLINT window.
- Writes: produces the registered w_wmtimecmp/w_clint_we and w_wmip/w_plic_we update pulses that feed back into the cluster.
- Reads: returns mtime, mtimecmp and msip with fixed 1-cycle latency.

Parameters:
- BASE, 32'h0200_0000, CLINT window base; window is BASE..BASE+0xFFFF.
- MSIP_BIT, 3, bit of mip driven by the msip register.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- w_data_addr  in  32  request address from cluster
- w_data_wdata  in  32  write data from cluster
- w_data_we  in  1  write strobe, 1-cycle
- w_data_re  in  1  read strobe, 1-cycle
- w_mtime  in  64  current mtime from cluster
- w_mtimecmp  in  64  current mtimecmp from cluster
- w_mip  in  32  current mip from cluster
- w_wmtimecmp  out  64  new mtimecmp value
- w_clint_we  out  1  mtimecmp update pulse
- w_wmip  out  32  new mip value
- w_plic_we  out  1  mip update pulse
- r_rdata  out  32  read data
- r_rvalid  out  1  read data valid pulse
- r_busy  out  1  high while a commit is in flight; requester holds strobes off

Behaviour:
- Hit: w_data_addr[31:16]==BASE[31:16]. Offsets: 0x0000 msip, 0x4000 mtimecmp lo, 0x4004 mtimecmp hi, 0xBFF8 mtime lo, 0xBFFC mtime hi. Other offsets in the window: writes ignored, reads return 0 with r_rvalid.
- Reset values: w_wmtimecmp=0, w_clint_we=0, w_wmip=0, w_plic_we=0, r_rdata=0, r_rvalid=0, r_busy=0, FSM=IDLE, shadow_lo=0, lo_pending=0.
- FSM IDLE -> COMMIT on an accepted hit write (we && hit && !r_busy). Capture offset and data at that edge; r_busy=1 in COMMIT.
- In COMMIT, for exactly one cycle:
  - msip: w_wmip = w_mip with bit MSIP_BIT replaced by wdata[0]; w_plic_we=1.
  - mtimecmp lo: w_wmtimecmp = {w_mtimecmp[63:32], wdata}; w_clint_we=1.
  - mtimecmp hi: w_wmtimecmp = {wdata, w_mtimecmp[31:0]}; w_clint_we=1.
  - mtime writes and unmapped writes: no pulse.
  - Next state is always IDLE.
- Write latency: strobe at edge N, pulse visible for cycle N+1 only; w_wmtimecmp/w_wmip hold their last value afterwards.
- A write strobe while r_busy=1 is dropped (protocol violation; bench asserts it never happens).
- Reads accepted in any state (re && hit): r_rdata/r_rvalid registered, valid on the next cycle.
  - mtimecmp reads return w_mtimecmp.
  - msip read returns {31'b0, w_mip[MSIP_BIT]}.
- Simultaneous we and re in the same cycle: the write wins; the read is ignored with no r_rvalid.
- Non-hit requests: no response, no state change.
- RST asserted mid-COMMIT: all pulses drop immediately (async) and the FSM returns to IDLE; the captured write is lost.

Optional Feature:
- Macro: CLINT_MTIMECMP_ATOMIC_EN.
- Defined: a lo write sets shadow_lo=wdata and lo_pending=1, and does NOT pulse w_clint_we; FSM still visits COMMIT for one cycle.
  - A following hi write pulses w_wmtimecmp = {wdata, lo_pending ? shadow_lo : w_mtimecmp[31:0]}, then clears lo_pending.
  - A read of the lo offset while lo_pending=1 returns shadow_lo.
- Undefined: each half commits independently as described in Behaviour; shadow_lo and lo_pending are not built.

Test Plan:
- Reset: RST=1 mid-COMMIT -> all outputs 0 within the same cycle; IDLE after release.
- msip write: addr 0x0200_0000, wdata 1, w_mip=0x80 -> next cycle w_wmip=0x88, w_plic_we=1 for 1 cycle, r_busy=1 for 1 cycle.
- mtimecmp hi write: w_mtimecmp=0x0000_0001_0000_0010, write 0x0200_4004 = 0xAB -> w_wmtimecmp=0x0000_00AB_0000_0010, w_clint_we=1 for 1 cycle.
- Atomic (macro on): write lo 0x55 then hi 0x2 -> no pulse after lo; after hi w_wmtimecmp=0x0000_0002_0000_0055; the lo write alone leaves w_clint_we=0.
- mtime read: w_mtime=0x1234_5678_9ABC_DEF0, re at 0x0200_BFFC -> next cycle r_rdata=0x1234_5678, r_rvalid=1.
- Edge cases:
  - Write to 0x0200_1000 -> no pulse, r_busy still 1 for 1 cycle.
  - Write and read in the same cycle -> write commits, no r_rvalid.
  - Write to 0x0300_0000 -> no activity.

Source files
------------

// File: rtl/clint_bridge.sv
// CLINT front end: decodes cluster data-port accesses to msip/mtimecmp/mtime in the BASE window.
// Optional CLINT_MTIMECMP_ATOMIC_EN: buffer mtimecmp lo writes until the hi half commits both.
module clint_bridge #(
  parameter logic [31:0] BASE     = 32'h0200_0000,
  parameter int          MSIP_BIT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] w_data_addr,
  input  logic [31:0] w_data_wdata,
  input  logic        w_data_we,
  input  logic        w_data_re,
  input  logic [63:0] w_mtime,
  input  logic [63:0] w_mtimecmp,
  input  logic [31:0] w_mip,
  output logic [63:0] w_wmtimecmp,
  output logic        w_clint_we,
  output logic [31:0] w_wmip,
  output logic        w_plic_we,
  output logic [31:0] r_rdata,
  output logic        r_rvalid,
  output logic        r_busy
);

  localparam logic [15:0] OFF_MSIP   = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI = 16'h4004;
  localparam logic [15:0] OFF_TIM_LO = 16'hBFF8;
  localparam logic [15:0] OFF_TIM_HI = 16'hBFFC;

  typedef enum logic {IDLE, COMMIT} state_t;

  state_t      state_q, state_d;
  logic [63:0] wmtimecmp_q, wmtimecmp_d;
  logic        clint_we_q, clint_we_d;
  logic [31:0] wmip_q, wmip_d;
  logic        plic_we_q, plic_we_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  logic        hit;
  logic [15:0] offset;
  logic        wr_acc;
  logic        rd_acc;

  assign hit    = (w_data_addr[31:16] == BASE[31:16]);
  assign offset = w_data_addr[15:0];
  assign wr_acc = w_data_we && hit && (state_q == IDLE);
  // A write strobe always takes precedence over a read in the same cycle.
  assign rd_acc = w_data_re && hit && !w_data_we;

`ifdef CLINT_MTIMECMP_ATOMIC_EN
  logic [31:0] shadow_lo_q, shadow_lo_d;
  logic        lo_pending_q, lo_pending_d;
`endif

  always_comb begin
    state_d     = wr_acc ? COMMIT : IDLE;
    wmtimecmp_d = wmtimecmp_q;
    clint_we_d  = 1'b0;
    wmip_d      = wmip_q;
    plic_we_d   = 1'b0;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
`ifdef CLINT_MTIMECMP_ATOMIC_EN
    shadow_lo_d  = shadow_lo_q;
    lo_pending_d = lo_pending_q;
`endif

    // Update values are formed at the accepting edge so the pulse lines up with COMMIT.
    if (wr_acc) begin
      case (offset)
        OFF_MSIP: begin
          wmip_d           = w_mip;
          wmip_d[MSIP_BIT] = w_data_wdata[0];
          plic_we_d        = 1'b1;
        end
        OFF_CMP_LO: begin
`ifdef CLINT_MTIMECMP_ATOMIC_EN
          shadow_lo_d  = w_data_wdata;
          lo_pending_d = 1'b1;
`else
          wmtimecmp_d = {w_mtimecmp[63:32], w_data_wdata};
          clint_we_d  = 1'b1;
`endif
        end
        OFF_CMP_HI: begin
`ifdef CLINT_MTIMECMP_ATOMIC_EN
          wmtimecmp_d  = {w_data_wdata, lo_pending_q ? shadow_lo_q : w_mtimecmp[31:0]};
          lo_pending_d = 1'b0;
`else
          wmtimecmp_d = {w_data_wdata, w_mtimecmp[31:0]};
`endif
          clint_we_d = 1'b1;
        end
        default: ;
      endcase
    end

    if (rd_acc) begin
      rvalid_d = 1'b1;
      case (offset)
        OFF_MSIP:   rdata_d = {31'b0, w_mip[MSIP_BIT]};
`ifdef CLINT_MTIMECMP_ATOMIC_EN
        OFF_CMP_LO: rdata_d = lo_pending_q ? shadow_lo_q : w_mtimecmp[31:0];
`else
        OFF_CMP_LO: rdata_d = w_mtimecmp[31:0];
`endif
        OFF_CMP_HI: rdata_d = w_mtimecmp[63:32];
        OFF_TIM_LO: rdata_d = w_mtime[31:0];
        OFF_TIM_HI: rdata_d = w_mtime[63:32];
        default:    rdata_d = 32'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      wmtimecmp_q <= 64'b0;
      clint_we_q  <= 1'b0;
      wmip_q      <= 32'b0;
      plic_we_q   <= 1'b0;
      rdata_q     <= 32'b0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wmtimecmp_q <= wmtimecmp_d;
      clint_we_q  <= clint_we_d;
      wmip_q      <= wmip_d;
      plic_we_q   <= plic_we_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

`ifdef CLINT_MTIMECMP_ATOMIC_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow_lo_q  <= 32'b0;
      lo_pending_q <= 1'b0;
    end else begin
      shadow_lo_q  <= shadow_lo_d;
      lo_pending_q <= lo_pending_d;
    end
  end
`endif

  assign w_wmtimecmp = wmtimecmp_q;
  assign w_clint_we  = clint_we_q;
  assign w_wmip      = wmip_q;
  assign w_plic_we   = plic_we_q;
  assign r_rdata     = rdata_q;
  assign r_rvalid    = rvalid_q;
  assign r_busy      = (state_q == COMMIT);

endmodule

// File: tb/tb_clint_bridge.sv
// Self-checking bench for clint_bridge: directed scenarios followed by randomized traffic
// compared against a transaction-level model of the CLINT register behaviour.
module tb_clint_bridge;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] w_data_addr;
  logic [31:0] w_data_wdata;
  logic        w_data_we;
  logic        w_data_re;
  logic [63:0] w_mtime;
  logic [63:0] w_mtimecmp;
  logic [31:0] w_mip;
  logic [63:0] w_wmtimecmp;
  logic        w_clint_we;
  logic [31:0] w_wmip;
  logic        w_plic_we;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the outputs should read after the next edge.
  logic [63:0] m_wmtimecmp;
  logic        m_clint_we;
  logic [31:0] m_wmip;
  logic        m_plic_we;
  logic [31:0] m_rdata;
  logic        m_rvalid;
  logic        m_busy;
  logic [31:0] m_shadow;
  logic        m_pending;

  clint_bridge dut (
    .CLK          (CLK),
    .RST          (RST),
    .w_data_addr  (w_data_addr),
    .w_data_wdata (w_data_wdata),
    .w_data_we    (w_data_we),
    .w_data_re    (w_data_re),
    .w_mtime      (w_mtime),
    .w_mtimecmp   (w_mtimecmp),
    .w_mip        (w_mip),
    .w_wmtimecmp  (w_wmtimecmp),
    .w_clint_we   (w_clint_we),
    .w_wmip       (w_wmip),
    .w_plic_we    (w_plic_we),
    .r_rdata      (r_rdata),
    .r_rvalid     (r_rvalid),
    .r_busy       (r_busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wmtimecmp = 64'b0;
    m_clint_we  = 1'b0;
    m_wmip      = 32'b0;
    m_plic_we   = 1'b0;
    m_rdata     = 32'b0;
    m_rvalid    = 1'b0;
    m_busy      = 1'b0;
    m_shadow    = 32'b0;
    m_pending   = 1'b0;
  endtask

  // One request cycle evaluated from the register map rules.
  task automatic model_step();
    logic        hit;
    logic [15:0] off;
    logic        wr;
    logic        rd;
    hit = (w_data_addr[31:16] == 16'h0200);
    off = w_data_addr[15:0];
    wr  = w_data_we && hit && !m_busy;
    rd  = w_data_re && hit && !w_data_we;
    m_clint_we = 1'b0;
    m_plic_we  = 1'b0;
    m_rvalid   = rd;
    if (rd) begin
      if (off == 16'h0000)      m_rdata = {31'b0, w_mip[3]};
      else if (off == 16'h4000) m_rdata = m_pending ? m_shadow : w_mtimecmp[31:0];
      else if (off == 16'h4004) m_rdata = w_mtimecmp[63:32];
      else if (off == 16'hBFF8) m_rdata = w_mtime[31:0];
      else if (off == 16'hBFFC) m_rdata = w_mtime[63:32];
      else                      m_rdata = 32'b0;
    end
    if (wr) begin
      if (off == 16'h0000) begin
        m_wmip    = (w_mip & ~32'h8) | (w_data_wdata[0] ? 32'h8 : 32'h0);
        m_plic_we = 1'b1;
      end else if (off == 16'h4000) begin
`ifdef CLINT_MTIMECMP_ATOMIC_EN
        m_shadow  = w_data_wdata;
        m_pending = 1'b1;
`else
        m_wmtimecmp = (w_mtimecmp & 64'hFFFF_FFFF_0000_0000) | 64'(w_data_wdata);
        m_clint_we  = 1'b1;
`endif
      end else if (off == 16'h4004) begin
        m_wmtimecmp = (64'(w_data_wdata) << 32) |
                      64'(m_pending ? m_shadow : w_mtimecmp[31:0]);
        m_pending   = 1'b0;
        m_clint_we  = 1'b1;
      end
    end
    m_busy = wr;
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".clint_we"},  w_clint_we,  m_clint_we);
    check({tag, ".wmtimecmp"}, w_wmtimecmp, m_wmtimecmp);
    check({tag, ".plic_we"},   w_plic_we,   m_plic_we);
    check({tag, ".wmip"},      w_wmip,      m_wmip);
    check({tag, ".busy"},      r_busy,      m_busy);
    check({tag, ".rvalid"},    r_rvalid,    m_rvalid);
    if (m_rvalid) check({tag, ".rdata"}, r_rdata, m_rdata);
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic we, input logic re);
    @(negedge CLK);
    if (we) check({tag, ".no_write_while_busy"}, r_busy, 1'b0);
    w_data_addr  = addr;
    w_data_wdata = wdata;
    w_data_we    = we;
    w_data_re    = re;
    model_step();
    @(posedge CLK);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(tag, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] offs [7];
    offs = '{32'h0000, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC, 32'h1000, 32'h0008};

    RST = 1'b1;
    w_data_addr = 32'h0; w_data_wdata = 32'h0; w_data_we = 1'b0; w_data_re = 1'b0;
    w_mtime = 64'h0; w_mtimecmp = 64'h0; w_mip = 32'h0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset");
    check("reset.rdata", r_rdata, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    idle("post_reset");

    // msip write sets mip bit 3 from wdata[0]
    w_mip = 32'h80;
    applyStimulus("msip_wr", 32'h0200_0000, 32'h1, 1'b1, 1'b0);
    check("msip_wr.wmip_const", w_wmip, 32'h88);
    check("msip_wr.plic_const", w_plic_we, 1'b1);
    check("msip_wr.busy_const", r_busy, 1'b1);
    idle("msip_after");
    check("msip_after.plic_const", w_plic_we, 1'b0);
    check("msip_after.wmip_hold", w_wmip, 32'h88);

    // mtimecmp hi write
    w_mtimecmp = 64'h0000_0001_0000_0010;
    applyStimulus("cmp_hi", 32'h0200_4004, 32'hAB, 1'b1, 1'b0);
    check("cmp_hi.value_const", w_wmtimecmp, 64'h0000_00AB_0000_0010);
    check("cmp_hi.clint_const", w_clint_we, 1'b1);
    idle("cmp_hi_after");
    check("cmp_hi_after.clint_const", w_clint_we, 1'b0);

    // lo then hi: atomic build defers the lo half
    applyStimulus("cmp_lo", 32'h0200_4000, 32'h55, 1'b1, 1'b0);
`ifdef CLINT_MTIMECMP_ATOMIC_EN
    check("cmp_lo.no_pulse", w_clint_we, 1'b0);
    idle("cmp_lo_gap");
    applyStimulus("cmp_lo_rd", 32'h0200_4000, 32'h0, 1'b0, 1'b1);
    check("cmp_lo_rd.shadow", r_rdata, 32'h55);
    applyStimulus("cmp_hi2", 32'h0200_4004, 32'h2, 1'b1, 1'b0);
    check("cmp_hi2.value_const", w_wmtimecmp, 64'h0000_0002_0000_0055);
`else
    check("cmp_lo.pulse", w_clint_we, 1'b1);
    check("cmp_lo.value_const", w_wmtimecmp, 64'h0000_0001_0000_0055);
    idle("cmp_lo_gap");
    applyStimulus("cmp_hi2", 32'h0200_4004, 32'h2, 1'b1, 1'b0);
    check("cmp_hi2.value_const", w_wmtimecmp, 64'h0000_0002_0000_0010);
`endif
    idle("cmp_hi2_after");

    // mtime hi read
    w_mtime = 64'h1234_5678_9ABC_DEF0;
    applyStimulus("mtime_rd", 32'h0200_BFFC, 32'h0, 1'b0, 1'b1);
    check("mtime_rd.rdata_const", r_rdata, 32'h1234_5678);
    check("mtime_rd.rvalid_const", r_rvalid, 1'b1);
    idle("mtime_rd_after");

    // unmapped write in window still occupies COMMIT
    applyStimulus("unmapped_wr", 32'h0200_1000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("unmapped_wr.busy_const", r_busy, 1'b1);
    idle("unmapped_after");
    check("unmapped_after.busy_const", r_busy, 1'b0);

    // write and read together: write wins
    w_mip = 32'h0;
    applyStimulus("wr_rd", 32'h0200_0000, 32'h1, 1'b1, 1'b1);
    check("wr_rd.rvalid_const", r_rvalid, 1'b0);
    check("wr_rd.plic_const", w_plic_we, 1'b1);
    idle("wr_rd_after");

    // outside window: nothing happens
    applyStimulus("miss_wr", 32'h0300_0000, 32'h1, 1'b1, 1'b1);
    check("miss_wr.busy_const", r_busy, 1'b0);
    idle("miss_after");

    // reset asserted while COMMIT is active
    applyStimulus("rst_commit", 32'h0200_4004, 32'h77, 1'b1, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("rst_mid.clint_we", w_clint_we, 1'b0);
    check("rst_mid.wmtimecmp", w_wmtimecmp, 64'h0);
    check("rst_mid.busy", r_busy, 1'b0);
    check("rst_mid.wmip", w_wmip, 32'h0);
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    w_data_we = 1'b0;
    w_data_re = 1'b0;
    idle("rst_release");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] addr;
      logic        we;
      logic        re;
      w_mtime    = {$urandom, $urandom};
      w_mtimecmp = {$urandom, $urandom};
      w_mip      = $urandom;
      addr = ($urandom_range(0, 7) == 0) ? (32'h0300_0000 | ($urandom & 32'hFFFF))
                                         : (32'h0200_0000 | offs[$urandom_range(0, 6)]);
      we = ($urandom_range(0, 2) == 0) && !m_busy;
      re = ($urandom_range(0, 1) == 0);
      applyStimulus("rand", addr, $urandom, we, re);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
